instruction_fetch: RTL and testbench

Pipeline IF stage of the MIPS core. It holds the PC, reads the byte-addressed instruction memory, and drives the IF/ID register that feeds instruction_decode.
- Accepts jump/branch redirects resolved in ID, plus stall from the hazard unit and freeze from the debug unit.
- Latches HALT (0xFFFFFFFF) detection.
- The instruction memory is loaded byte-by-byte by the debug/UART loader.

---
 rtl/pipeline_defs.sv | 26 ++
 rtl/instruction_memory.sv | 30 +++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline constants for the MIPS core, plus the IF-stage per-edge action.
package pipeline_defs;

    localparam logic [31:0] NOP_INSTR  = '0;
    localparam logic [31:0] HALT_INSTR = '1;
    localparam logic [31:0] PC_STEP    = 32'd4;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    // What the IF stage does on the coming edge, listed in priority order.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FREEZE,
        ACT_DRAIN,
        ACT_HOLD,
        ACT_REDIRECT,
        ACT_FETCH
    } fetch_action_e;

endpackage

// File: rtl/instruction_memory.sv
// Byte-addressed instruction memory: byte write port, combinational big-endian word read.
module instruction_memory #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [7:0]        write_data_i,
    input  logic [ADDR_W-3:0] read_word_i,
    output logic [31:0]       read_data_o
);

    logic [7:0] mem_q [MEM_BYTES];

    // No reset: a loaded program must survive a core reset.
    always_ff @(posedge clk_i) begin
        if (write_en_i) begin
            mem_q[write_addr_i] <= write_data_i;
        end
    end

    always_comb begin
        read_data_o = {mem_q[{read_word_i, 2'b00}],
                       mem_q[{read_word_i, 2'b01}],
                       mem_q[{read_word_i, 2'b10}],
                       mem_q[{read_word_i, 2'b11}]};
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC register, redirect/stall/freeze priority and the IF/ID register.
module instruction_fetch
    import pipeline_defs::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic              i_stall,
    input  logic              i_jump,
    input  logic [31:0]       i_jump_address,
    input  logic              i_mem_write_en,
    input  logic [ADDR_W-1:0] i_mem_write_addr,
    input  logic [7:0]        i_mem_write_data,
    output logic [31:0]       o_instruction,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_debug,
    output logic              o_halted
);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pc_next_q, pc_next_d;
    logic          halted_q, halted_d;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_plus4;
    fetch_action_e action;
    logic [1:0]    unused_jump_lsbs;

    assign unused_jump_lsbs = i_jump_address[1:0];
    assign pc_plus4         = pc_q + PC_STEP;

    instruction_memory #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_imem (
        .clk_i        (i_clk),
        .write_en_i   (i_mem_write_en),
        .write_addr_i (i_mem_write_addr),
        .write_data_i (i_mem_write_data),
        .read_word_i  (pc_q[ADDR_W-1:2]),
        .read_data_o  (fetch_word)
    );

    always_ff @(posedge i_clk) begin
        pc_q      <= pc_d;
        instr_q   <= instr_d;
        pc_next_q <= pc_next_d;
        halted_q  <= halted_d;
    end

    always_comb begin
        if (i_reset)       action = ACT_RESET;
        else if (i_halt)   action = ACT_FREEZE;
        else if (halted_q) action = ACT_DRAIN;
        else if (i_stall)  action = ACT_HOLD;
        else if (i_jump)   action = ACT_REDIRECT;
        else               action = ACT_FETCH;
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        halted_d  = halted_q;
        unique case (action)
            ACT_RESET: begin
                pc_d      = '0;
                instr_d   = NOP_INSTR;
                pc_next_d = '0;
                halted_d  = 1'b0;
            end
            ACT_FREEZE, ACT_HOLD: ;
            ACT_DRAIN: instr_d = NOP_INSTR;
            ACT_REDIRECT: begin
                // Flush the fetched word (even a HALT); no delay slot.
                pc_d      = {i_jump_address[31:2], 2'b00};
                instr_d   = NOP_INSTR;
                pc_next_d = '0;
            end
            ACT_FETCH: begin
                instr_d   = fetch_word;
                pc_next_d = pc_plus4;
                if (fetch_word == HALT_INSTR) halted_d = 1'b1;
                else                          pc_d     = pc_plus4;
            end
            default: ;
        endcase
    end

    assign o_instruction = instr_q;
    assign o_pc          = pc_next_q;
    assign o_pc_debug    = pc_q;
    assign o_halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector tables plus randomized run vs. a reference model.
module tb_instruction_fetch;

    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        rst, hlt, stl, jmp, we;
    logic [31:0] ja;
    logic [9:0]  wa;
    logic [7:0]  wd;
    logic [31:0] ins, opc, dbg;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    byte unsigned m_mem [MEM];
    logic [31:0]  m_pc = 0, m_ins = 0, m_opc = 0;
    logic         m_h = 0;

    typedef struct packed {
        logic        rst, hlt, stl, jmp;
        logic [31:0] ja;
        logic        we;
        logic [9:0]  wa;
        logic [7:0]  wd;
        logic [31:0] e_ins, e_pc, e_dbg;
        logic        e_h;
    } vec_t;

    vec_t tab [$];

    instruction_fetch #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_halt           (hlt),
        .i_stall          (stl),
        .i_jump           (jmp),
        .i_jump_address   (ja),
        .i_mem_write_en   (we),
        .i_mem_write_addr (wa),
        .i_mem_write_data (wd),
        .o_instruction    (ins),
        .o_pc             (opc),
        .o_pc_debug       (dbg),
        .o_halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        int base;
        base = int'(pc % MEM) / 4 * 4;
        return (32'(m_mem[base]) << 24) | (32'(m_mem[base+1]) << 16) |
               (32'(m_mem[base+2]) << 8) | 32'(m_mem[base+3]);
    endfunction

    // Reference behaviour for one rising edge, from the priority rules.
    task automatic model_step();
        logic [31:0] w;
        w = model_word(m_pc);
        if (rst) begin
            m_pc = 0; m_ins = 0; m_opc = 0; m_h = 0;
        end else if (hlt) begin
        end else if (m_h) begin
            m_ins = 0;
        end else if (stl) begin
        end else if (jmp) begin
            m_pc = ja / 4 * 4; m_ins = 0; m_opc = 0;
        end else begin
            m_ins = w;
            m_opc = m_pc + 4;
            if (w == 32'hFFFFFFFF) m_h = 1;
            else m_pc = m_pc + 4;
        end
        if (we) m_mem[int'(wa)] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; hlt = 0; stl = 0; jmp = 0; ja = 0; we = 0; wa = 0; wd = 0;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] w);
        for (int unsigned b = 0; b < 4; b++) begin
            rst = 1; we = 1; wa = a + 10'(b); wd = w[31 - 8*b -: 8];
            tick();
        end
        idle();
        rst = 1;
        tick();
        idle();
    endtask

    function automatic vec_t mk(input logic r, h, s, j, input logic [31:0] jaddr,
                                input logic w, input logic [9:0] waddr, input logic [7:0] wdata,
                                input logic [31:0] ei, ep, ed, input logic eh);
        vec_t v;
        v.rst = r; v.hlt = h; v.stl = s; v.jmp = j; v.ja = jaddr;
        v.we = w; v.wa = waddr; v.wd = wdata;
        v.e_ins = ei; v.e_pc = ep; v.e_dbg = ed; v.e_h = eh;
        return v;
    endfunction

    task automatic run_table();
        foreach (tab[i]) begin
            rst = tab[i].rst; hlt = tab[i].hlt; stl = tab[i].stl; jmp = tab[i].jmp;
            ja = tab[i].ja; we = tab[i].we; wa = tab[i].wa; wd = tab[i].wd;
            tick();
            chk($sformatf("tab%0d.instr", i), ins, tab[i].e_ins);
            chk($sformatf("tab%0d.pc", i), opc, tab[i].e_pc);
            chk($sformatf("tab%0d.pc_debug", i), dbg, tab[i].e_dbg);
            chk($sformatf("tab%0d.halted", i), 32'(halted), 32'(tab[i].e_h));
        end
        tab.delete();
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        chk("reset.instr", ins, 0);
        chk("reset.pc", opc, 0);
        chk("reset.pc_debug", dbg, 0);
        chk("reset.halted", 32'(halted), 0);

        // Program A: two instructions then HALT; freeze with a loader write, then reset.
        load_word(10'h000, 32'h20010005);
        load_word(10'h004, 32'h20020003);
        load_word(10'h008, 32'hFFFFFFFF);
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h20010005, 4, 4, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h20020003, 8, 8, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'hFFFFFFFF, 12, 8, 1));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h0, 12, 8, 1));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h0, 12, 8, 1));
        for (int k = 0; k < 3; k++)
            tab.push_back(mk(0,1,0,0,0, 1,10'h003,8'hAB, 32'h0, 12, 8, 1));
        tab.push_back(mk(1,0,0,0,0, 0,0,0, 32'h0, 0, 0, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h200100AB, 4, 4, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h20020003, 8, 8, 0));
        run_table();

        // Program B: straight line, stalls, stall+jump, redirect, jump over a HALT slot.
        for (int k = 0; k < 5; k++) load_word(10'(4*k), 32'h10000000 + k);
        load_word(10'h014, 32'hFFFFFFFF);
        for (int k = 0; k < 4; k++) load_word(10'(32'h40 + 4*k), 32'hA0A00040 + 4*k);
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h10000000, 4, 4, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h10000001, 8, 8, 0));
        tab.push_back(mk(0,1,0,0,0, 0,0,0, 32'h10000001, 8, 8, 0));
        tab.push_back(mk(0,0,1,0,0, 0,0,0, 32'h10000001, 8, 8, 0));
        tab.push_back(mk(0,0,1,0,0, 0,0,0, 32'h10000001, 8, 8, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h10000002, 12, 12, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'h10000003, 16, 16, 0));
        tab.push_back(mk(0,0,1,1,32'h42, 0,0,0, 32'h10000003, 16, 16, 0));
        tab.push_back(mk(0,0,0,1,32'h42, 0,0,0, 32'h0, 0, 32'h40, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'hA0A00040, 32'h44, 32'h44, 0));
        tab.push_back(mk(0,0,0,1,32'h17, 0,0,0, 32'h0, 0, 32'h14, 0));
        tab.push_back(mk(0,0,0,1,32'h4A, 0,0,0, 32'h0, 0, 32'h48, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'hA0A00048, 32'h4C, 32'h4C, 0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 32'hA0A0004C, 32'h50, 32'h50, 0));
        run_table();

        // Randomized run: fill the whole memory, then random control against the model.
        for (int k = 0; k < MEM; k += 4) begin
            logic [31:0] w;
            w = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom;
            for (int b = 0; b < 4; b++) begin
                rst = 1; we = 1; wa = 10'(k + b); wd = w[31 - 8*b -: 8];
                tick();
            end
        end
        idle();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            hlt = ($urandom_range(0, 9) == 0);
            stl = ($urandom_range(0, 6) == 0);
            jmp = ($urandom_range(0, 6) == 0);
            ja  = $urandom;
            we  = ($urandom_range(0, 4) == 0);
            wa  = 10'($urandom_range(0, MEM - 1));
            wd  = 8'($urandom);
            tick();
            chk("rand.instr", ins, m_ins);
            chk("rand.pc", opc, m_opc);
            chk("rand.pc_debug", dbg, m_pc);
            chk("rand.halted", 32'(halted), 32'(m_h));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
